// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller.
// Walks FETCH/DECODE/EXEC/MEM/WB per instruction, latching opcode and funct
// in FETCH so that every control output follows the latched fields and never
// the live instruction bus. Also counts retired instructions.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  npcsel,
  output logic [1:0]  RegDst,
  output logic        ALUSrc,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  EXTop,
  output logic [1:0]  ALUctr,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] icount
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } ctrlState_t;

  typedef enum logic [3:0] {
    K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_BAD
  } instrKind_t;

  ctrlState_t curState;
  instrKind_t kind;
  logic [5:0] opReg;
  logic [5:0] functReg;
  logic       lastState;
  logic       unusedInstrBits;

  // The register and immediate fields are consumed by the datapath, not here.
  assign unusedInstrBits = ^instr[25:6];

  assign state = curState;

  // Classify the latched opcode/funct pair; anything unrecognised is illegal.
  always_comb begin
    kind = K_BAD;
    case (opReg)
      6'b000000: begin
        case (functReg)
          6'b100001: kind = K_ADDU;
          6'b100011: kind = K_SUBU;
          6'b001000: kind = K_JR;
          default:   kind = K_BAD;
        endcase
      end
      6'b001101: kind = K_ORI;
      6'b001111: kind = K_LUI;
      6'b100011: kind = K_LW;
      6'b101011: kind = K_SW;
      6'b000100: kind = K_BEQ;
      6'b000011: kind = K_JAL;
      default:   kind = K_BAD;
    endcase
  end

  // Control outputs from state plus instruction kind; reset low silences them all.
  always_comb begin
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    npcsel    = 2'b00;
    RegDst    = 2'b00;
    ALUSrc    = 1'b0;
    MemtoReg  = 2'b00;
    EXTop     = 2'b00;
    ALUctr    = 2'b00;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    illegal   = 1'b0;
    lastState = 1'b0;
    if (reset) begin
      case (curState)
        DECODE:  lastState = (kind == K_JR) || (kind == K_BAD);
        EXEC:    lastState = (kind == K_BEQ);
        MEM:     lastState = (kind == K_SW);
        WB:      lastState = 1'b1;
        default: lastState = 1'b0;
      endcase
      IRWrite  = (curState == FETCH);
      PCWrite  = lastState;
      RegWrite = (curState == WB);
      MemWrite = (curState == MEM) && (kind == K_SW);
      illegal  = (curState == DECODE) && (kind == K_BAD);
      if (curState != FETCH) begin
        case (kind)
          K_ADDU: begin RegDst = 2'b01; ALUctr = 2'b00; end
          K_SUBU: begin RegDst = 2'b01; ALUctr = 2'b01; end
          K_JR:   npcsel = 2'b11;
          K_ORI:  begin ALUSrc = 1'b1; ALUctr = 2'b10; EXTop = 2'b00; end
          K_LUI:  begin ALUSrc = 1'b1; ALUctr = 2'b10; EXTop = 2'b10; end
          K_LW:   begin ALUSrc = 1'b1; EXTop = 2'b01; MemtoReg = 2'b01; end
          K_SW:   begin ALUSrc = 1'b1; EXTop = 2'b01; end
          K_BEQ:  begin npcsel = 2'b01; ALUctr = 2'b01; end
          K_JAL:  begin npcsel = 2'b10; RegDst = 2'b10; MemtoReg = 2'b10; end
          default: npcsel = 2'b00;
        endcase
      end
    end
  end

  // State sequencing, field latching in FETCH and retired-instruction counting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      curState <= FETCH;
      opReg    <= 6'd0;
      functReg <= 6'd0;
      icount   <= 32'd0;
    end else begin
      if (PCWrite) begin
        icount <= icount + 32'd1;
      end
      case (curState)
        FETCH: begin
          opReg    <= instr[31:26];
          functReg <= instr[5:0];
          curState <= DECODE;
        end
        DECODE: begin
          if (kind == K_JAL) begin
            curState <= WB;
          end else if ((kind == K_JR) || (kind == K_BAD)) begin
            curState <= FETCH;
          end else begin
            curState <= EXEC;
          end
        end
        EXEC: begin
          if ((kind == K_LW) || (kind == K_SW)) begin
            curState <= MEM;
          end else if (kind == K_BEQ) begin
            curState <= FETCH;
          end else begin
            curState <= WB;
          end
        end
        MEM: begin
          if (kind == K_LW) begin
            curState <= WB;
          end else begin
            curState <= FETCH;
          end
        end
        WB:      curState <= FETCH;
        default: curState <= FETCH;
      endcase
    end
  end

endmodule
